// File: rtl/axis_step_glide.sv
// axis_step_glide
//   Phase-step slew limiter that sits in front of the NCO step input. A new
//   target step arrives on an AXI-Stream slave. The output step then moves
//   toward that target in fixed increments, one increment every cfg_div+1
//   clocks. A frequency change therefore becomes a linear glide and never
//   reaches the noise-shaper chain as an instantaneous jump. The output word
//   is continuously valid, so it can feed the NCO with tvalid tied high.
//
// Ports
//   aclk                clock
//   arst                synchronous active-high reset
//   s_axis_data_tdata   target phase step (unsigned)
//   s_axis_data_tvalid  target valid
//   s_axis_data_tready  target accepted when high together with tvalid
//   cfg_div             clocks between ramp updates, minus one
//   cfg_delta           step increment per update; zero requests an immediate jump
//   m_axis_data_tdata   current phase step
//   m_axis_data_tvalid  output valid; held high from the first cycle after reset
//   busy                high while a ramp is in progress
//   done                one-cycle pulse when the output has reached the target
module axis_step_glide #(
  parameter int ACC_WIDTH = 32,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [ACC_WIDTH-1:0] s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [ACC_WIDTH-1:0] cfg_delta,
  output logic [ACC_WIDTH-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_next;

  logic [ACC_WIDTH-1:0] cur;
  logic [ACC_WIDTH-1:0] cur_next;
  logic [ACC_WIDTH-1:0] tgt;
  logic [ACC_WIDTH-1:0] tgt_next;
  logic [ACC_WIDTH-1:0] delta_l;
  logic [ACC_WIDTH-1:0] delta_next;
  logic [DIV_WIDTH-1:0] div_l;
  logic [DIV_WIDTH-1:0] div_next;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_next;
  logic                 done_r;
  logic                 done_next;
  logic                 out_vld;

  logic                 accept;
  logic [ACC_WIDTH:0]   diff;

  // Distance between two unsigned steps, one bit wider than the operands so
  // the subtraction can never wrap.
  function automatic logic [ACC_WIDTH:0] abs_diff(
    input logic [ACC_WIDTH-1:0] a,
    input logic [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] aw;
    logic [ACC_WIDTH:0] bw;
    aw = {1'b0, a};
    bw = {1'b0, b};
    return (aw >= bw) ? (aw - bw) : (bw - aw);
  endfunction

  // One increment toward the target. Only called when the remaining distance
  // exceeds the increment, so the result stays strictly between cur and tgt
  // and cannot wrap past zero or full scale.
  function automatic logic [ACC_WIDTH-1:0] step_toward(
    input logic [ACC_WIDTH-1:0] c,
    input logic [ACC_WIDTH-1:0] t,
    input logic [ACC_WIDTH-1:0] d
  );
    return (t > c) ? (c + d) : (c - d);
  endfunction

  // out_vld is low only while reset is being applied, which also keeps
  // tready low across the reset window.
  assign s_axis_data_tready = (state == IDLE) && out_vld;
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;
  assign diff               = abs_diff(tgt, cur);

  assign m_axis_data_tdata  = cur;
  assign m_axis_data_tvalid = out_vld;
  assign busy               = (state == RAMP);
  assign done               = done_r;

  always_ff @(posedge aclk) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cur_next   = cur;
    tgt_next   = tgt;
    delta_next = delta_l;
    div_next   = div_l;
    cnt_next   = cnt;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          tgt_next   = s_axis_data_tdata;
          delta_next = cfg_delta;
          div_next   = cfg_div;
          if (s_axis_data_tdata == cur) begin
            done_next = 1'b1;
          end else if (cfg_delta == '0) begin
            cur_next  = s_axis_data_tdata;
            done_next = 1'b1;
          end else begin
            cnt_next   = cfg_div;
            state_next = RAMP;
          end
        end
      end

      RAMP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else if (diff <= {1'b0, delta_l}) begin
          // Final (possibly partial) increment lands exactly on the target.
          cur_next   = tgt;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cur_next = step_toward(cur, tgt, delta_l);
          cnt_next = div_l;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      cur     <= '0;
      tgt     <= '0;
      cnt     <= '0;
      done_r  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      cur     <= cur_next;
      tgt     <= tgt_next;
      cnt     <= cnt_next;
      done_r  <= done_next;
      out_vld <= 1'b1;
    end
  end

  // Increment and divider are only read in RAMP, after a fresh accept has
  // loaded them, so they carry no reset.
  always_ff @(posedge aclk) begin
    delta_l <= delta_next;
    div_l   <= div_next;
  end

endmodule

// File: tb/tb_axis_step_glide.sv
module tb_axis_step_glide;

  logic        aclk;
  logic        arst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] cfg_div;
  logic [31:0] cfg_delta;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          k;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  axis_step_glide #(
    .ACC_WIDTH(32),
    .DIV_WIDTH(16)
  ) dut (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .cfg_div            (cfg_div),
    .cfg_delta          (cfg_delta),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .busy               (busy),
    .done               (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: pushes every expected output change (cycle index k after
  // the accept edge, value) into the scoreboard and returns the cycle at
  // which done should pulse.
  task automatic model_ramp(input logic [31:0] start, input logic [31:0] target,
                            input int div, input logic [31:0] delta, input int k0,
                            output int done_k, output bit ramp);
    longint c, t, d, rem;
    int     j;
    exp_t   e;
    c = start; t = target; d = delta;
    ramp = 1'b0; done_k = k0; j = 0;
    if (c != t) begin
      if (d == 0) begin
        e.k = k0; e.val = target; exp_q.push_back(e);
      end else begin
        ramp = 1'b1;
        while (c != t) begin
          j++;
          rem = (t > c) ? (t - c) : (c - t);
          if (rem <= d) c = t;
          else if (t > c) c = c + d;
          else c = c - d;
          e.k = k0 + j * (div + 1);
          e.val = c[31:0];
          exp_q.push_back(e);
        end
        done_k = k0 + j * (div + 1);
      end
    end
  endtask

  // Presents one target and returns just after the edge that accepted it.
  task automatic send(input logic [31:0] t, input logic [15:0] div,
                      input logic [31:0] delta, output bit ok);
    int i;
    ok = 1'b0; i = 0;
    @(posedge aclk); #1;
    s_tdata = t; cfg_div = div; cfg_delta = delta; s_tvalid = 1'b1;
    while (!ok && i < 200) begin
      @(negedge aclk);
      if (s_tready === 1'b1) begin
        @(posedge aclk); #1;
        ok = 1'b1;
      end
      i++;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (3) @(posedge aclk);
    #1 arst = 1'b0;
    @(negedge aclk);
    tests++; if (m_tdata !== 32'd0) begin fails++; $display("FAIL rst_tdata: got %0d want 0", m_tdata); end
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL rst_tready: got %b want 0", s_tready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL idle_tvalid k=%0d: got %b want 1", k, m_tvalid); end
      tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL idle_tready k=%0d: got %b want 1", k, s_tready); end
      tests++; if (m_tdata !== 32'd0) begin fails++; $display("FAIL idle_tdata k=%0d: got %0d want 0", k, m_tdata); end
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_flags k=%0d: done=%b busy=%b want 0 0", k, done, busy); end
    end
  endtask

  task automatic test_up_ramp();
    int done_k; bit ramp; bit ok; logic [31:0] prev; exp_t e;
    model_ramp(32'd0, 32'd4500, 3, 32'd1000, 0, done_k, ramp);
    send(32'd4500, 16'd3, 32'd1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL up_accept: no handshake within budget, want accept"); end
    prev = 32'd0;
    for (int k = 0; k <= done_k + 2; k++) begin
      @(negedge aclk);
      if (m_tdata !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL up_step: unexpected tdata %0d at k=%0d, want %0d", m_tdata, k, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.val !== m_tdata || e.k != k) begin
            fails++; $display("FAIL up_step: got %0d at k=%0d, want %0d at k=%0d", m_tdata, k, e.val, e.k);
          end
        end
        prev = m_tdata;
      end
      tests++; if (done !== (k == done_k)) begin fails++; $display("FAIL up_done k=%0d: got %b want %b", k, done, (k == done_k)); end
      tests++; if (busy !== (ramp && k < done_k)) begin fails++; $display("FAIL up_busy k=%0d: got %b want %b", k, busy, (ramp && k < done_k)); end
      tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL up_tvalid k=%0d: got %b want 1", k, m_tvalid); end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL up_missing: %0d updates outstanding, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_down_ramp();
    int done_k; bit ramp; bit ok; logic [31:0] prev; exp_t e;
    model_ramp(32'd4500, 32'd0, 0, 32'd1500, 0, done_k, ramp);
    send(32'd0, 16'd0, 32'd1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL down_accept: no handshake within budget, want accept"); end
    prev = 32'd4500;
    for (int k = 0; k <= done_k + 2; k++) begin
      @(negedge aclk);
      if (m_tdata !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL down_step: unexpected tdata %0d at k=%0d, want %0d", m_tdata, k, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.val !== m_tdata || e.k != k) begin
            fails++; $display("FAIL down_step: got %0d at k=%0d, want %0d at k=%0d", m_tdata, k, e.val, e.k);
          end
        end
        prev = m_tdata;
      end
      tests++; if (done !== (k == done_k)) begin fails++; $display("FAIL down_done k=%0d: got %b want %b", k, done, (k == done_k)); end
      tests++; if (busy !== (ramp && k < done_k)) begin fails++; $display("FAIL down_busy k=%0d: got %b want %b", k, busy, (ramp && k < done_k)); end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL down_missing: %0d updates outstanding, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_bypass();
    int done_k; bit ramp; bit ok; logic [31:0] prev; exp_t e;
    // Zero increment: immediate jump, then the same target again.
    for (int pass = 0; pass < 2; pass++) begin
      prev = (pass == 0) ? 32'd0 : 32'd2748800;
      model_ramp(prev, 32'd2748800, 0, 32'd0, 0, done_k, ramp);
      send(32'd2748800, 16'd0, 32'd0, ok);
      tests++; if (!ok) begin fails++; $display("FAIL byp_accept pass=%0d: no handshake, want accept", pass); end
      for (int k = 0; k < 4; k++) begin
        @(negedge aclk);
        if (m_tdata !== prev) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL byp_step pass=%0d: unexpected tdata %0d at k=%0d, want %0d", pass, m_tdata, k, prev);
          end else begin
            e = exp_q.pop_front();
            if (e.val !== m_tdata || e.k != k) begin
              fails++; $display("FAIL byp_step pass=%0d: got %0d at k=%0d, want %0d at k=%0d", pass, m_tdata, k, e.val, e.k);
            end
          end
          prev = m_tdata;
        end
        tests++; if (done !== (k == done_k)) begin fails++; $display("FAIL byp_done pass=%0d k=%0d: got %b want %b", pass, k, done, (k == done_k)); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL byp_busy pass=%0d k=%0d: got %b want 0", pass, k, busy); end
      end
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL byp_missing pass=%0d: %0d outstanding, want 0", pass, exp_q.size()); end
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, acc_k; bit r1, r2, ok, pending, bexp; logic [31:0] prev; exp_t e;
    model_ramp(32'd2748800, 32'd2751800, 7, 32'd1000, 0, d1, r1);
    model_ramp(32'd2751800, 32'd2748800, 1, 32'd2000, d1 + 1, d2, r2);
    send(32'd2751800, 16'd7, 32'd1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_accept: no handshake within budget, want accept"); end
    // Next target (and altered cfg) held pending while the ramp runs.
    s_tdata = 32'd2748800; cfg_div = 16'd1; cfg_delta = 32'd2000; s_tvalid = 1'b1;
    pending = 1'b1; acc_k = -1; prev = 32'd2748800;
    for (int k = 0; k <= d2 + 2; k++) begin
      @(negedge aclk);
      bexp = (k < d1) || (k > d1 && k < d2);
      if (m_tdata !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL bp_step: unexpected tdata %0d at k=%0d, want %0d", m_tdata, k, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.val !== m_tdata || e.k != k) begin
            fails++; $display("FAIL bp_step: got %0d at k=%0d, want %0d at k=%0d", m_tdata, k, e.val, e.k);
          end
        end
        prev = m_tdata;
      end
      tests++; if (s_tready !== !bexp) begin fails++; $display("FAIL bp_tready k=%0d: got %b want %b", k, s_tready, !bexp); end
      tests++; if (busy !== bexp) begin fails++; $display("FAIL bp_busy k=%0d: got %b want %b", k, busy, bexp); end
      tests++; if (done !== (k == d1 || k == d2)) begin fails++; $display("FAIL bp_done k=%0d: got %b want %b", k, done, (k == d1 || k == d2)); end
      if (pending && s_tready === 1'b1) begin
        acc_k = k;
        tests++; if (acc_k != d1) begin fails++; $display("FAIL bp_accept_cycle: accepted at k=%0d, want k=%0d", acc_k, d1); end
        @(posedge aclk); #1;
        s_tvalid = 1'b0; pending = 1'b0;
      end
    end
    s_tvalid = 1'b0;
    tests++; if (pending) begin fails++; $display("FAIL bp_pending: second target never accepted, want accept at k=%0d", d1); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp_missing: %0d updates outstanding, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_ramp();
    int done_k; bit ramp; bit ok; logic [31:0] prev; exp_t e;
    send(32'd0, 16'd0, 32'd0, ok);
    @(negedge aclk);
    tests++; if (!ok || m_tdata !== 32'd0) begin fails++; $display("FAIL mid_preset: got %0d ok=%b want 0 ok=1", m_tdata, ok); end
    send(32'd10000, 16'd1, 32'd1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_accept: no handshake within budget, want accept"); end
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      if (k == 2) begin
        tests++; if (m_tdata !== 32'd1000) begin fails++; $display("FAIL mid_first: got %0d want 1000", m_tdata); end
      end
    end
    // Reset sampled on the edge that would carry the second update.
    tests++; if (m_tdata !== 32'd1000 || busy !== 1'b1) begin fails++; $display("FAIL mid_pre_rst: tdata=%0d busy=%b want 1000 1", m_tdata, busy); end
    arst = 1'b1;
    @(negedge aclk);
    arst = 1'b0;
    tests++; if (m_tdata !== 32'd0) begin fails++; $display("FAIL mid_rst_tdata: got %0d want 0", m_tdata); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mid_rst_flags: busy=%b done=%b want 0 0", busy, done); end
    tests++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin fails++; $display("FAIL mid_rst_hs: tvalid=%b tready=%b want 0 0", m_tvalid, s_tready); end
    @(negedge aclk);
    tests++; if (m_tvalid !== 1'b1 || s_tready !== 1'b1 || done !== 1'b0 || m_tdata !== 32'd0) begin
      fails++; $display("FAIL mid_release: tvalid=%b tready=%b done=%b tdata=%0d want 1 1 0 0", m_tvalid, s_tready, done, m_tdata);
    end
    model_ramp(32'd0, 32'd3000, 0, 32'd1000, 0, done_k, ramp);
    send(32'd3000, 16'd0, 32'd1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_reaccept: no handshake within budget, want accept"); end
    prev = 32'd0;
    for (int k = 0; k <= done_k + 1; k++) begin
      @(negedge aclk);
      if (m_tdata !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL mid_step: unexpected tdata %0d at k=%0d, want %0d", m_tdata, k, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.val !== m_tdata || e.k != k) begin
            fails++; $display("FAIL mid_step: got %0d at k=%0d, want %0d at k=%0d", m_tdata, k, e.val, e.k);
          end
        end
        prev = m_tdata;
      end
      tests++; if (done !== (k == done_k)) begin fails++; $display("FAIL mid_done k=%0d: got %b want %b", k, done, (k == done_k)); end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL mid_missing: %0d updates outstanding, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    arst = 1'b1;
    s_tdata = 32'd0;
    s_tvalid = 1'b0;
    cfg_div = 16'd0;
    cfg_delta = 32'd0;
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_bypass();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
